// File: rtl/pdp8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pdp8_pkg
// Purpose  : Shared PDP-8 I/O definitions used by the peripheral devices.
//            It holds the device codes, the IOT pulse bit positions and the
//            reader FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package pdp8_pkg;

  // IOT device codes on the shared bus
  localparam logic [5:0] DEV_KBD  = 6'o03;
  localparam logic [5:0] DEV_TTY  = 6'o04;
  localparam logic [5:0] DEV_PR   = 6'o01;
  localparam logic [5:0] DEV_PP   = 6'o02;

  // Paper-tape reader IOT pulse bits within mb[2:0]
  localparam int IOT_RSF = 0;   // skip on flag
  localparam int IOT_RRB = 1;   // read buffer into AC, clear flag
  localparam int IOT_RFC = 2;   // clear flag, fetch next character

  // Width of the reader character delay counter
  localparam int PR_TIMER_W = 16;

  // Reader fetch sequencer states
  typedef enum logic [1:0] {
    PR_IDLE  = 2'd0,
    PR_FETCH = 2'd1,
    PR_DELAY = 2'd2
  } pr_state_e;

endpackage : pdp8_pkg
`default_nettype wire

// File: rtl/pdp8_pr_timer.sv
`default_nettype none
// ============================================================================
// Module   : pdp8_pr_timer
// Purpose  : Loadable down-counter that models the reader's per-character
//            mechanical delay. It saturates at zero and flags zero.
// Revision : 1.0 - initial release
// ============================================================================
module pdp8_pr_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Load takes priority; otherwise count down and hold at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule : pdp8_pr_timer
`default_nettype wire

// File: rtl/pdp8_pr.sv
`default_nettype none
// ============================================================================
// Module   : pdp8_pr
// Purpose  : PDP-8 high-speed paper-tape reader. It decodes the RSF, RRB and
//            RFC IOTs once per IOT. It fetches one tape byte per RFC over a
//            valid/ready handshake. It raises the flag a fixed number of
//            cycles after each byte is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module pdp8_pr
  import pdp8_pkg::*;
#(
  parameter logic [5:0] DEV_CODE   = DEV_PR,
  parameter int         CHAR_DELAY = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [3:0]  state,
  input  logic [11:0] mb,
  input  logic [11:0] io_data_in,
  input  logic [5:0]  io_select,
  output logic        io_selected,
  output logic [11:0] io_data_out,
  output logic        io_data_avail,
  output logic        io_interrupt,
  output logic        io_skip,
  output logic        io_clear_ac,
  input  logic        tape_valid,
  input  logic [7:0]  tape_data,
  output logic        tape_ready
);

  localparam logic [PR_TIMER_W-1:0] c_delay_load = PR_TIMER_W'(CHAR_DELAY - 1);

  pr_state_e r_state;
  logic      r_flag;
  logic [7:0] r_buf;
  logic      r_tape_ready;
  logic      r_sel_d;

  logic w_selected;
  logic w_exec;
  logic w_accept;
  logic w_timer_zero;
  logic w_flag_set;
  logic w_flag_clr;
  logic w_unused;

  // The CPU major state and AC are not needed to qualify reader IOTs.
  assign w_unused = ^{state, io_data_in, mb[11:3]};

  assign w_selected = iot & (io_select == DEV_CODE);
  // An IOT may stay on the bus for several cycles. Its pulses act only on
  // the first cycle.
  assign w_exec     = w_selected & ~r_sel_d;
  assign w_accept   = (r_state == PR_FETCH) & tape_valid & r_tape_ready;
  assign w_flag_set = (r_state == PR_DELAY) & w_timer_zero;
  // An IOT that executes this cycle beats a flag set in the same cycle.
  assign w_flag_clr = w_exec & (mb[IOT_RRB] | mb[IOT_RFC]);

  // Registered copy of the select used for first-cycle edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_d <= 1'b0;
    end else begin
      r_sel_d <= w_selected;
    end
  end

  // Fetch sequencer with registered handshake, buffer and flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= PR_IDLE;
      r_flag       <= 1'b0;
      r_buf        <= 8'o0;
      r_tape_ready <= 1'b0;
    end else begin
      case (r_state)
        PR_IDLE: begin
          if (w_exec && mb[IOT_RFC]) begin
            r_state      <= PR_FETCH;
            r_tape_ready <= 1'b1;
          end
        end
        PR_FETCH: begin
          // Wait here indefinitely until the tape source supplies a byte.
          if (w_accept) begin
            r_buf        <= tape_data;
            r_tape_ready <= 1'b0;
            r_state      <= PR_DELAY;
          end
        end
        PR_DELAY: begin
          if (w_timer_zero) begin
            r_state <= PR_IDLE;
          end
        end
        default: begin
          r_state      <= PR_IDLE;
          r_tape_ready <= 1'b0;
        end
      endcase

      if (w_flag_clr) begin
        r_flag <= 1'b0;
      end else if (w_flag_set) begin
        r_flag <= 1'b1;
      end
    end
  end

  pdp8_pr_timer #(
    .WIDTH (PR_TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_accept),
    .i_load_val (c_delay_load),
    .i_dec      (r_state == PR_DELAY),
    .o_zero     (w_timer_zero)
  );

  assign io_selected   = w_selected;
  assign io_data_out   = (w_selected && mb[IOT_RRB]) ? {4'b0000, r_buf} : 12'o0000;
  assign io_data_avail = w_selected & mb[IOT_RRB];
  assign io_clear_ac   = w_selected & mb[IOT_RRB];
  assign io_skip       = w_selected & mb[IOT_RSF] & r_flag;
  assign io_interrupt  = r_flag;
  assign tape_ready    = r_tape_ready;

endmodule : pdp8_pr
`default_nettype wire

// File: tb/tb_pdp8_pr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pdp8_pr
// Purpose  : Self-checking bench for the paper-tape reader. The bytes
//            expected back from RRB are queued when they are fed from tape.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdp8_pr;

  localparam int         CD  = 16;
  localparam logic [5:0] DEV = 6'o01;

  logic        clk = 1'b0;
  logic        reset;
  logic        iot;
  logic [3:0]  state;
  logic [11:0] mb;
  logic [11:0] io_data_in;
  logic [5:0]  io_select;
  logic        io_selected;
  logic [11:0] io_data_out;
  logic        io_data_avail;
  logic        io_interrupt;
  logic        io_skip;
  logic        io_clear_ac;
  logic        tape_valid;
  logic [7:0]  tape_data;
  logic        tape_ready;

  int errors = 0;
  int checks = 0;
  logic [11:0] q_exp[$];
  logic [11:0] exp_v;

  pdp8_pr #(.DEV_CODE(DEV), .CHAR_DELAY(CD)) dut (
    .clk(clk), .reset(reset), .iot(iot), .state(state), .mb(mb),
    .io_data_in(io_data_in), .io_select(io_select), .io_selected(io_selected),
    .io_data_out(io_data_out), .io_data_avail(io_data_avail),
    .io_interrupt(io_interrupt), .io_skip(io_skip), .io_clear_ac(io_clear_ac),
    .tape_valid(tape_valid), .tape_data(tape_data), .tape_ready(tape_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Start an IOT just after a rising edge, then stop at the falling edge.
  task automatic iot_begin(input logic [5:0] dev, input logic [2:0] bits);
    @(posedge clk); #1;
    iot = 1'b1; io_select = dev; mb = {9'b0, bits};
    @(negedge clk);
  endtask

  task automatic iot_end();
    @(posedge clk); #1;
    iot = 1'b0; io_select = 6'o00; mb = 12'o0;
  endtask

  // Present a byte until the reader accepts it. On return the accepting
  // edge has just passed.
  task automatic feed(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    tape_data = b; tape_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (tape_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    tape_valid = 1'b0;
  endtask

  task automatic wait_flag(input int maxc, output int n);
    n = 0;
    while (!io_interrupt && n < maxc) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; iot = 1'b0; state = 4'd0; mb = 12'o0; io_data_in = 12'o7777;
    io_select = 6'o00; tape_valid = 1'b0; tape_data = 8'o0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tape_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", tape_ready); end
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", io_interrupt); end
    checks++; if ({io_selected, io_data_out, io_data_avail, io_skip, io_clear_ac} !== 16'h0) begin
      errors++; $display("FAIL reset_outs: got sel=%b data=%o avail=%b skip=%b clr=%b want all 0",
                         io_selected, io_data_out, io_data_avail, io_skip, io_clear_ac); end
    @(posedge clk); #1; reset = 1'b1;
  endtask

  task automatic test_rsf_idle();
    iot_begin(DEV, 3'b001);
    checks++; if (io_selected !== 1'b1) begin errors++; $display("FAIL rsf_idle_sel: got %b want 1", io_selected); end
    checks++; if (io_skip !== 1'b0) begin errors++; $display("FAIL rsf_idle_skip: got %b want 0", io_skip); end
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL rsf_idle_irq: got %b want 0", io_interrupt); end
    iot_end();
  endtask

  task automatic test_fetch_basic();
    bit ok; int n;
    iot_begin(DEV, 3'b100);
    iot_end();
    checks++; if (tape_ready !== 1'b1) begin errors++; $display("FAIL rfc_ready: got %b want 1", tape_ready); end
    q_exp.push_back(12'o0215);
    feed(8'o215, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fetch_accept: got no accept want accept"); end
    checks++; if (tape_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready_drop: got %b want 0", tape_ready); end
    wait_flag(CD + 4, n);
    checks++; if (n != CD) begin errors++; $display("FAIL fetch_delay: got %0d cycles want %0d", n, CD); end
    iot_begin(DEV, 3'b001);
    checks++; if (io_skip !== 1'b1) begin errors++; $display("FAIL fetch_rsf: got %b want 1", io_skip); end
    iot_end();
    iot_begin(DEV, 3'b010);
    exp_v = (q_exp.size() > 0) ? q_exp.pop_front() : 12'oxxxx;
    checks++; if (io_data_out !== exp_v) begin errors++; $display("FAIL fetch_rrb_data: got %o want %o", io_data_out, exp_v); end
    checks++; if ({io_clear_ac, io_data_avail} !== 2'b11) begin errors++; $display("FAIL fetch_rrb_ctl: got clr=%b avail=%b want 1 1", io_clear_ac, io_data_avail); end
    iot_end();
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL fetch_rrb_flag: got %b want 0", io_interrupt); end
  endtask

  task automatic test_combined();
    bit ok; int n;
    iot_begin(DEV, 3'b100); iot_end();
    q_exp.push_back(12'o0101);
    feed(8'o101, ok);
    wait_flag(CD + 4, n);
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL comb_first_flag: got %b want 1", io_interrupt); end
    iot_begin(DEV, 3'b110);
    exp_v = (q_exp.size() > 0) ? q_exp.pop_front() : 12'oxxxx;
    checks++; if (io_data_out !== exp_v) begin errors++; $display("FAIL comb_6016_data: got %o want %o", io_data_out, exp_v); end
    iot_end();
    checks++; if ({io_interrupt, tape_ready} !== 2'b01) begin errors++; $display("FAIL comb_6016_state: got flag=%b ready=%b want 0 1", io_interrupt, tape_ready); end
    q_exp.push_back(12'o0102);
    feed(8'o102, ok);
    wait_flag(CD + 4, n);
    checks++; if (n != CD) begin errors++; $display("FAIL comb_second_delay: got %0d want %0d", n, CD); end
    iot_begin(DEV, 3'b010);
    exp_v = (q_exp.size() > 0) ? q_exp.pop_front() : 12'oxxxx;
    checks++; if (io_data_out !== exp_v) begin errors++; $display("FAIL comb_second_data: got %o want %o", io_data_out, exp_v); end
    iot_end();
  endtask

  task automatic test_empty_tape();
    bit ok; int n;
    iot_begin(DEV, 3'b100); iot_end();
    repeat (1000) @(posedge clk);
    @(negedge clk);
    checks++; if ({tape_ready, io_interrupt} !== 2'b10) begin errors++; $display("FAIL empty_hold: got ready=%b flag=%b want 1 0", tape_ready, io_interrupt); end
    @(posedge clk); #1;
    q_exp.push_back(12'o0055);
    feed(8'o055, ok);
    wait_flag(CD + 4, n);
    checks++; if (n != CD) begin errors++; $display("FAIL empty_delay: got %0d want %0d", n, CD); end
    iot_begin(DEV, 3'b010);
    exp_v = (q_exp.size() > 0) ? q_exp.pop_front() : 12'oxxxx;
    checks++; if (io_data_out !== exp_v) begin errors++; $display("FAIL empty_data: got %o want %o", io_data_out, exp_v); end
    iot_end();
  endtask

  task automatic test_rfc_during_delay();
    bit ok; int n; int acc;
    iot_begin(DEV, 3'b100); iot_end();
    q_exp.push_back(12'o0123);
    feed(8'o123, ok);
    repeat (2) @(posedge clk);
    iot_begin(DEV, 3'b100); iot_end();
    tape_data = 8'o321; tape_valid = 1'b1;
    wait_flag(2 * CD, n);
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL rfc_delay_flag: got %b want 1", io_interrupt); end
    acc = 0;
    for (int i = 0; i < 2 * CD; i++) begin
      @(negedge clk);
      if (tape_ready && tape_valid) acc++;
    end
    tape_valid = 1'b0;
    checks++; if (acc != 0) begin errors++; $display("FAIL rfc_delay_extra: got %0d accepts want 0", acc); end
    iot_begin(DEV, 3'b010);
    exp_v = (q_exp.size() > 0) ? q_exp.pop_front() : 12'oxxxx;
    checks++; if (io_data_out !== exp_v) begin errors++; $display("FAIL rfc_delay_data: got %o want %o", io_data_out, exp_v); end
    iot_end();
  endtask

  task automatic test_reset_mid_delay();
    bit ok; int rises;
    iot_begin(DEV, 3'b100); iot_end();
    feed(8'o066, ok);
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    checks++; if ({tape_ready, io_interrupt} !== 2'b00) begin errors++; $display("FAIL rst_mid_outs: got ready=%b flag=%b want 0 0", tape_ready, io_interrupt); end
    @(posedge clk); #1; reset = 1'b1;
    rises = 0;
    for (int i = 0; i < 3 * CD; i++) begin
      @(negedge clk);
      if (io_interrupt) rises++;
    end
    checks++; if (rises != 0) begin errors++; $display("FAIL rst_mid_flag: got %0d flagged cycles want 0", rises); end
    q_exp.push_back(12'o0000);
    iot_begin(DEV, 3'b010);
    exp_v = (q_exp.size() > 0) ? q_exp.pop_front() : 12'oxxxx;
    checks++; if (io_data_out !== exp_v) begin errors++; $display("FAIL rst_mid_buf: got %o want %o", io_data_out, exp_v); end
    iot_end();
  endtask

  task automatic test_iot_hold();
    int acc;
    q_exp.push_back(12'o0252);
    tape_data = 8'o252; tape_valid = 1'b1;
    @(posedge clk); #1;
    iot = 1'b1; io_select = DEV; mb = 12'o0004;
    acc = 0;
    for (int i = 0; i < 5 + 3 * CD; i++) begin
      @(negedge clk);
      if (tape_ready && tape_valid) acc++;
      if (i == 4) begin @(posedge clk); #1; iot = 1'b0; mb = 12'o0; io_select = 6'o00; end
    end
    tape_valid = 1'b0;
    checks++; if (acc != 1) begin errors++; $display("FAIL hold_accepts: got %0d want 1", acc); end
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL hold_flag: got %b want 1", io_interrupt); end
    iot_begin(6'o03, 3'b111);
    checks++; if ({io_selected, io_data_out, io_data_avail, io_skip, io_clear_ac} !== 16'h0) begin
      errors++; $display("FAIL other_dev_outs: got sel=%b data=%o avail=%b skip=%b clr=%b want all 0",
                         io_selected, io_data_out, io_data_avail, io_skip, io_clear_ac); end
    iot_end();
    checks++; if ({io_interrupt, tape_ready} !== 2'b10) begin errors++; $display("FAIL other_dev_state: got flag=%b ready=%b want 1 0", io_interrupt, tape_ready); end
    iot_begin(DEV, 3'b010);
    exp_v = (q_exp.size() > 0) ? q_exp.pop_front() : 12'oxxxx;
    checks++; if (io_data_out !== exp_v) begin errors++; $display("FAIL hold_data: got %o want %o", io_data_out, exp_v); end
    iot_end();
  endtask

  initial begin
    test_reset();
    test_rsf_idle();
    test_fetch_basic();
    test_combined();
    test_empty_tape();
    test_rfc_during_delay();
    test_reset_mid_delay();
    test_iot_hold();
    checks++; if (q_exp.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d entries want 0", q_exp.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pdp8_pr
`default_nettype wire
